// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg
// Shared types and helpers for the time-multiplexed serial pattern detector.
//   ch_w_of / cnt_w_of : widths of a channel id and of a channel count
//   CH_W / CNT_W       : those widths for the default 4-channel build
//   ch_state_t         : per-channel record {hist, fill}, sized for the
//                        largest supported pattern; bits above PAT_LEN stay 0
//   next_ptr           : round-robin pointer advance with wrap
package seq_detect_pkg;

    localparam int MAX_PAT_LEN = 16;
    localparam int FILL_W      = 5;   // holds 0..MAX_PAT_LEN
    localparam int DEF_N_CH    = 4;

    function automatic int ch_w_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w_of(input int n);
        return $clog2(n) + 1;
    endfunction

    localparam int CH_W  = ch_w_of(DEF_N_CH);
    localparam int CNT_W = cnt_w_of(DEF_N_CH);

    typedef struct packed {
        logic [MAX_PAT_LEN-1:0] hist;
        logic [FILL_W-1:0]      fill;
    } ch_state_t;

    // Channel after 'cur', wrapping from n-1 back to 0.
    function automatic int next_ptr(input int cur, input int n);
        return (cur + 1 >= n) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/seq_detect_scheduler_rr_arbiter.sv
// rr_arbiter
// Round-robin one-hot grant over N_CH requesters.
//   clk, rst_n : clock, synchronous active-low reset (pointer -> 0)
//   eligible   : per-channel request mask (already qualified by enable)
//   accept     : the granted request was taken this cycle; advance pointer
//   grant      : one-hot grant, combinational from eligible and pointer
// The search starts at the pointer and wraps; after an accepted grant the
// pointer moves just past the winner, so every eligible channel is served
// within N_CH-1 cycles of waiting.
module rr_arbiter
    import seq_detect_pkg::*;
#(
    parameter int N_CH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] eligible,
    input  logic            accept,
    output logic [N_CH-1:0] grant
);

    localparam int PTR_W = $clog2(N_CH);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] win;
    logic             found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        win   = ptr;
        for (int k = 0; k < N_CH; k++) begin
            idx = PTR_W'((int'(ptr) + k) % N_CH);
            if (!found && eligible[idx]) begin
                grant[idx] = 1'b1;
                win        = idx;
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= PTR_W'(next_ptr(int'(win), N_CH));
        end
    end

endmodule

// File: rtl/seq_detect_scheduler.sv
// seq_detect_scheduler
// One pattern-match engine shared by N_CH serial channels. A round-robin
// arbiter accepts at most one bit per cycle; each channel keeps its own
// history and fill count so detection matches a dedicated per-channel
// detector on the accepted bit stream.
//   clk, rst_n  : clock, synchronous active-low reset
//   en          : per-channel enable (disabled channels are never granted,
//                 their state is kept)
//   req_valid   : channel i presents req_bit[i]
//   req_bit     : serial bit per channel
//   req_ready   : one-hot grant
//   ch_clr      : synchronous clear of a channel's history and fill
//   match_valid : one-cycle pulse, one clock after the completing bit
//   match_ch    : channel of the latest match, held between matches
//   busy_cnt    : number of channels with non-zero fill (registered)
//
// Handshake: a bit transfers on a rising edge where req_valid[i] and
// req_ready[i] are both high; the requester holds valid and bit stable until
// then. req_ready depends on req_valid, so the requester must not make
// req_valid depend on req_ready.
module seq_detect_scheduler
    import seq_detect_pkg::*;
#(
    parameter int                 N_CH    = 4,
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1010,
    parameter bit                 OVERLAP = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH-1:0]          en,
    input  logic [N_CH-1:0]          req_valid,
    input  logic [N_CH-1:0]          req_bit,
    output logic [N_CH-1:0]          req_ready,
    input  logic [N_CH-1:0]          ch_clr,
    output logic                     match_valid,
    output logic [$clog2(N_CH)-1:0]  match_ch,
    output logic [$clog2(N_CH):0]    busy_cnt
);

    localparam int ID_W   = $clog2(N_CH);
    localparam int BUSY_W = $clog2(N_CH) + 1;

    localparam logic [FILL_W-1:0]      FILL_FULL = FILL_W'(PAT_LEN);
    localparam logic [FILL_W-1:0]      FILL_ONE  = FILL_W'(1);
    // Keeps history bits above PAT_LEN at zero.
    localparam logic [MAX_PAT_LEN-1:0] HIST_MASK =
        MAX_PAT_LEN'((64'd1 << PAT_LEN) - 64'd1);

    ch_state_t st_q [N_CH];
    ch_state_t st_d [N_CH];

    logic [N_CH-1:0]        grant;
    logic [N_CH-1:0]        take;
    logic [N_CH-1:0]        hit;
    logic                   accept;
    logic [ID_W-1:0]        hit_idx;
    logic [BUSY_W-1:0]      busy_d;
    logic [MAX_PAT_LEN-1:0] hist_new;
    logic [FILL_W-1:0]      fill_new;

    rr_arbiter #(
        .N_CH (N_CH)
    ) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .eligible (en & req_valid),
        .accept   (accept),
        .grant    (grant)
    );

    assign req_ready = rst_n ? grant : '0;
    assign take      = req_valid & req_ready;
    assign accept    = |take;

    // Next channel state. ch_clr outranks an accepted bit on the same
    // channel: the bit is consumed by the handshake but discarded.
    always_comb begin
        hit      = '0;
        hist_new = '0;
        fill_new = '0;
        for (int i = 0; i < N_CH; i++) begin
            st_d[i]  = st_q[i];
            hist_new = {st_q[i].hist[MAX_PAT_LEN-2:0], req_bit[i]} & HIST_MASK;
            fill_new = (st_q[i].fill == FILL_FULL) ? FILL_FULL
                                                   : st_q[i].fill + FILL_ONE;
            if (ch_clr[i]) begin
                st_d[i] = '0;
            end else if (take[i]) begin
                if (hist_new[PAT_LEN-1:0] == PATTERN && fill_new == FILL_FULL) begin
                    hit[i] = 1'b1;
                    // Without overlap the next match needs PAT_LEN fresh bits.
                    if (!OVERLAP) begin
                        fill_new = '0;
                    end
                end
                st_d[i].hist = hist_new;
                st_d[i].fill = fill_new;
            end
        end
    end

    // At most one channel is accepted per cycle, so hit is at most one-hot.
    always_comb begin
        hit_idx = '0;
        busy_d  = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (hit[i]) begin
                hit_idx = ID_W'(i);
            end
            if (st_d[i].fill != '0) begin
                busy_d = busy_d + BUSY_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                st_q[i] <= '0;
            end
            match_valid <= 1'b0;
            match_ch    <= '0;
            busy_cnt    <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                st_q[i] <= st_d[i];
            end
            match_valid <= |hit;
            if (|hit) begin
                match_ch <= hit_idx;
            end
            busy_cnt <= busy_d;
        end
    end

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Bench for seq_detect_scheduler: two instances (overlap on / off) share the
// same stimulus. A bit-queue model of each channel's accepted stream is
// compared against both instances on every falling edge; directed literal
// expectations pin the model at key points.
module tb_seq_detect_scheduler;
    import seq_detect_pkg::*;

    localparam int N = 4;
    localparam int L = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0] en = '1;
    logic [N-1:0] req_valid = '0;
    logic [N-1:0] req_bit = '0;
    logic [N-1:0] ch_clr = '0;

    logic [N-1:0]     rdy_a, rdy_b;
    logic             mv_a, mv_b;
    logic [CH_W-1:0]  mch_a, mch_b;
    logic [CNT_W-1:0] busy_a, busy_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_detect_scheduler #(.N_CH(N), .PAT_LEN(L), .PATTERN(4'b1010), .OVERLAP(1'b1)) u_ovl (
        .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid), .req_bit(req_bit),
        .req_ready(rdy_a), .ch_clr(ch_clr), .match_valid(mv_a), .match_ch(mch_a),
        .busy_cnt(busy_a)
    );

    seq_detect_scheduler #(.N_CH(N), .PAT_LEN(L), .PATTERN(4'b1010), .OVERLAP(1'b0)) u_novl (
        .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid), .req_bit(req_bit),
        .req_ready(rdy_b), .ch_clr(ch_clr), .match_valid(mv_b), .match_ch(mch_b),
        .busy_cnt(busy_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // bq[k][ch]: the channel's accepted bits since its last restart, oldest
    // first, trimmed to the last L bits. k=0 overlap, k=1 no overlap.
    bit       bq [2][N][$];
    int       m_ptr = 0;
    bit       m_mv [2] = '{0, 0};
    int       m_mch [2] = '{0, 0};
    int       m_busy [2] = '{0, 0};
    logic [L-1:0] pat_v = 4'b1010;

    function automatic logic [N-1:0] model_grant();
        logic [N-1:0] g;
        g = '0;
        if (rst_n) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (g == '0 && en[c] && req_valid[c]) g[c] = 1'b1;
            end
        end
        return g;
    endfunction

    always @(negedge clk) begin
        logic [N-1:0] g;
        g = model_grant();
        check("ready_ovl", 32'(rdy_a), 32'(g));
        check("ready_novl", 32'(rdy_b), 32'(g));
        check("mvalid_ovl", 32'(mv_a), 32'(m_mv[0]));
        check("mvalid_novl", 32'(mv_b), 32'(m_mv[1]));
        check("mch_ovl", 32'(mch_a), 32'(m_mch[0]));
        check("mch_novl", 32'(mch_b), 32'(m_mch[1]));
        check("busy_ovl", 32'(busy_a), 32'(m_busy[0]));
        check("busy_novl", 32'(busy_b), 32'(m_busy[1]));

        // advance the model to the state after the coming rising edge
        if (!rst_n) begin
            m_ptr = 0;
            for (int k = 0; k < 2; k++) begin
                m_mv[k] = 0; m_mch[k] = 0; m_busy[k] = 0;
                for (int c = 0; c < N; c++) bq[k][c].delete();
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_mv[k] = 0;
                for (int c = 0; c < N; c++) begin
                    if (ch_clr[c]) begin
                        bq[k][c].delete();
                    end else if (g[c]) begin
                        bit same;
                        bq[k][c].push_back(req_bit[c]);
                        if (bq[k][c].size() > L) void'(bq[k][c].pop_front());
                        same = (bq[k][c].size() == L);
                        for (int j = 0; j < L && same; j++)
                            if (bq[k][c][j] != pat_v[L-1-j]) same = 0;
                        if (same) begin
                            m_mv[k] = 1;
                            m_mch[k] = c;
                            if (k == 1) bq[k][c].delete();
                        end
                    end
                end
                m_busy[k] = 0;
                for (int c = 0; c < N; c++) if (bq[k][c].size() > 0) m_busy[k]++;
            end
            for (int c = 0; c < N; c++) if (g[c]) m_ptr = (c + 1) % N;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = '1; req_valid = '0; ch_clr = '0; req_bit = '0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic send(input int ch, input bit b);
        req_valid = '0;
        req_valid[ch] = 1'b1;
        req_bit[ch] = b;
        tick();
        req_valid = '0;
    endtask

    initial begin
        int idx [N];
        tick();
        check("reset_busy", 32'(busy_a), 32'd0);
        check("reset_mv", 32'(mv_a), 32'd0);
        do_reset();

        // ch0 stream 1,0,1,0,1,0 then 1,0
        send(0, 1); send(0, 0); send(0, 1); send(0, 0);
        check("t1_match4_ovl", 32'({mv_a, mch_a}), 32'({1'b1, 2'd0}));
        check("t2_match4_novl", 32'(mv_b), 32'd1);
        send(0, 1);
        check("t1_nomatch5", 32'(mv_a), 32'd0);
        send(0, 0);
        check("t1_match6_ovl", 32'(mv_a), 32'd1);
        check("t2_nomatch6_novl", 32'(mv_b), 32'd0);
        send(0, 1); send(0, 0);
        check("t2_match8_novl", 32'(mv_b), 32'd1);
        check("t1_match8_ovl", 32'(mv_a), 32'd1);

        // all four channels valid, each fed 1010
        do_reset();
        req_valid = '1;
        for (int c = 0; c < N; c++) idx[c] = 0;
        for (int c = 0; c < 16; c++) begin
            for (int ch = 0; ch < N; ch++) if (idx[ch] < L) req_bit[ch] = pat_v[L-1-idx[ch]];
            #1;
            check("t3_rr_grant", 32'(rdy_a), 32'(1 << (c % N)));
            idx[c % N]++;
            tick();
            if (c >= 12) check("t3_match_ch", 32'({mv_a, mch_a}), 32'({1'b1, 2'(c % N)}));
        end
        req_valid = '0;
        tick();
        check("t3_busy_ovl", 32'(busy_a), 32'd4);
        check("t3_busy_novl", 32'(busy_b), 32'd0);

        // clear coinciding with the final bit
        do_reset();
        send(1, 1); send(1, 0); send(1, 1);
        ch_clr = 4'b0010;
        send(1, 0);
        ch_clr = '0;
        check("t4_clr_nomatch", 32'(mv_a), 32'd0);
        check("t4_clr_busy", 32'(busy_a), 32'd0);
        send(1, 1); send(1, 0); send(1, 1); send(1, 0);
        check("t4_match_ch1", 32'({mv_a, mch_a}), 32'({1'b1, 2'd1}));
        check("t4_match_novl", 32'({mv_b, mch_b}), 32'({1'b1, 2'd1}));

        // reset in mid-stream
        do_reset();
        send(2, 1); send(2, 0); send(2, 1);
        req_valid = '1;
        rst_n = 1'b0;
        #1;
        check("t5_ready_in_reset", 32'(rdy_a), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("t5_first_grant", 32'(rdy_a), 32'b0001);
        req_valid = '0;
        send(2, 0);
        check("t5_nomatch", 32'(mv_a), 32'd0);
        check("t5_busy", 32'(busy_a), 32'd1);

        // ch0 disabled mid-pattern
        do_reset();
        send(0, 1); send(0, 0); send(0, 1);
        en = 4'b1110;
        req_valid = '1;
        req_bit = '0;
        for (int c = 0; c < 6; c++) begin
            #1;
            check("t6_grant_skip0", 32'(rdy_a), 32'(1 << (1 + c % 3)));
            tick();
        end
        en = '1;
        req_valid = '0;
        send(0, 0);
        check("t6_resume_match", 32'({mv_a, mch_a}), 32'({1'b1, 2'd0}));
        check("t6_resume_novl", 32'(mv_b), 32'd1);

        tick(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_detect_scheduler.md
Name: seq_detect_scheduler

Overview:
Time-multiplexes one serial pattern-match engine across N independent serial input channels.
- Round-robin arbitration accepts at most one bit per cycle.
- Each channel keeps its own history and fill count, so detection per channel is identical to a dedicated detector on that channel's accepted bit stream.
- Sits between serial front-ends and the event/interrupt logic; reports one registered match pulse tagged with a channel id.

Parameters:
N_CH, 4, number of serial channels (2..16)
PAT_LEN, 4, pattern length in bits (2..16)
PATTERN, 4'b1010, target pattern; MSB is the first-received bit
OVERLAP, 1, 1 = overlapping matches allowed; 0 = channel history restarts after a match

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
en  in  N_CH  per-channel enable; a disabled channel is never granted
req_valid  in  N_CH  channel i presents a bit
req_bit  in  N_CH  serial bit of channel i
req_ready  out  N_CH  one-hot grant; bit accepted when req_valid[i] & req_ready[i]
ch_clr  in  N_CH  synchronous clear of channel i history
match_valid  out  1  one-cycle pulse: pattern completed
match_ch  out  clog2(N_CH)  channel that matched; held until next match
busy_cnt  out  clog2(N_CH)+1  count of channels with non-zero fill

Behaviour:
- Reset: synchronous. While rst_n=0 at a rising edge, the following clear: all histories, all fill counts, rr pointer=0, match_valid=0, match_ch=0, busy_cnt=0.
- req_ready is combinational from en, req_valid and the pointer. It is forced to 0 while rst_n=0.
- Arbitration:
  - Eligible set = en & req_valid.
  - Grant the first eligible channel searching from ptr, ptr+1, … wrapping at N_CH-1 → 0.
  - On acceptance, ptr ← granted+1 (mod N_CH). With no acceptance, ptr holds.
  - A requester must hold valid and bit stable until accepted. Fairness bound: worst-case wait of N_CH-1 cycles.
- Per-channel state:
  - hist[i], PAT_LEN bits.
  - fill[i], saturates at PAT_LEN.
  - Accepted bit b: hist ← {hist[PAT_LEN-2:0], b}; fill ← min(fill+1, PAT_LEN).
- Match condition: the post-update hist equals PATTERN and the post-update fill equals PAT_LEN.
  - Registered output: match_valid=1 and match_ch=i in the cycle after the accepting edge.
  - Latency is 1 clock from acceptance.
- After a match:
  - OVERLAP=1: history kept (1010 then 10 gives a second match).
  - OVERLAP=0: fill[i] ← 0 at the same edge, so the next match needs PAT_LEN fresh bits.
- ch_clr[i]: fill[i] ← 0 and hist[i] ← 0 at the edge.
  - If ch_clr[i] coincides with acceptance on channel i, clear wins. The bit is consumed (ready was high) but discarded, and no match is reported.
- en[i]=0 does not clear state. History resumes when re-enabled.
- Only one channel is accepted per cycle, so match collisions are impossible.
- busy_cnt is registered and reflects fill values after the edge.
- Unused upper bits of match_ch are 0. Unused upper bits of hist are 0.

Decomposition:
- Package seq_detect_pkg holds the following, derived from N_CH/PAT_LEN:
  - CH_W and CNT_W localparams;
  - the channel-state record type {hist, fill};
  - a helper for next-pointer wrap.
- Sub-module rr_arbiter (N_CH) holds the pointer register and combinational one-hot grant, and takes an accept input to advance.
- Top holds the per-channel state array, the match compare and the output registers.

Test Plan:
(N_CH=4, PAT_LEN=4, PATTERN=1010.)
1. ch0 only, bits 1,0,1,0,1,0, OVERLAP=1 → match_valid one cycle after the 4th and 6th acceptance, match_ch=0; no other pulses.
2. Same stream, OVERLAP=0 → single match after the 4th; bits 5,6 give none; a following 1,0 gives a match after the 8th.
3. All four valid continuously with en=4'hF → req_ready sequence 0001,0010,0100,1000,0001…; each channel fed 1010 → matches on ch0..ch3 on consecutive cycles, each one cycle after its acceptance.
4. ch1 fed 1,0,1, then ch_clr[1] together with accepted bit 0 → no match, fill[1]=0; then 1,0,1,0 → match_ch=1.
5. ch2 fed 1,0,1, then rst_n=0 for one cycle, then bit 0 → no match; ptr restarts at 0, and with all valid the first grant is ch0.
6. en=4'b1110 with all req_valid=1 → req_ready[0] never asserts, grants rotate 1,2,3; ch0 state preserved and a match completes once en[0]=1 and its final bit is accepted.
